// File: rtl/string_match_sequencer.sv
// Sequencer for serial string matching: consumes (a,b) pairs over valid/ready, counts the
// current run of equal pairs and uses an external comparator to detect a run of target length.
module string_match_sequencer #(
    parameter int CW       = 4,
    parameter int MAX_BITS = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] target,
    input  logic          bit_valid,
    input  logic          a,
    input  logic          b,
    output logic          bit_ready,
    output logic [CW-1:0] datapath_in1,
    output logic [CW-1:0] datapath_in2,
    input  logic          datapath_out,
    output logic          busy,
    output logic          done,
    output logic          y_val,
    output logic [CW-1:0] match_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] BITS_LAST = CW'(MAX_BITS);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] run_cnt;
    logic [CW-1:0] bits_seen;
    logic [CW-1:0] target_q;
    logic          pair_eq;

    assign pair_eq      = ~(a ^ b);
    assign datapath_in1 = run_cnt;
    assign datapath_in2 = target_q;
    assign match_count  = run_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        bit_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (target == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
                if (bit_valid) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (datapath_out || (bits_seen == BITS_LAST)) begin
                    state_next = DONE;
                end else begin
                    state_next = RUN;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // An empty target matches trivially, so y_val is already 1 while DONE is visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt   <= '0;
            bits_seen <= '0;
            target_q  <= '0;
            y_val     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        target_q  <= target;
                        run_cnt   <= '0;
                        bits_seen <= '0;
                        y_val     <= (target == '0);
                    end
                end
                RUN: begin
                    if (bit_valid) begin
                        if (!pair_eq) begin
                            run_cnt <= '0;
                        end else if (run_cnt != CNT_MAX) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                        bits_seen <= bits_seen + 1'b1;
                    end
                end
                CHECK: begin
                    // A hit wins over running out of pairs on the same check.
                    if (datapath_out) begin
                        y_val <= 1'b1;
                    end else if (bits_seen == BITS_LAST) begin
                        y_val <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_string_match_sequencer.sv
// Bench for string_match_sequencer: directed searches with literal expectations, plus a
// transaction-level model checked against every output on every falling clock edge.
module tb_string_match_sequencer;

    localparam int CW   = 4;
    localparam int MAXB = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] target = '0;
    logic          bit_valid = 1'b0;
    logic          a = 1'b0;
    logic          b = 1'b0;
    logic          bit_ready;
    logic [CW-1:0] datapath_in1;
    logic [CW-1:0] datapath_in2;
    logic          datapath_out;
    logic          busy;
    logic          done;
    logic          y_val;
    logic [CW-1:0] match_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // External 4-bit equality comparator.
    assign datapath_out = (datapath_in1 == datapath_in2);

    string_match_sequencer #(.CW(CW), .MAX_BITS(MAXB)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .target(target),
        .bit_valid(bit_valid),
        .a(a),
        .b(b),
        .bit_ready(bit_ready),
        .datapath_in1(datapath_in1),
        .datapath_in2(datapath_in2),
        .datapath_out(datapath_out),
        .busy(busy),
        .done(done),
        .y_val(y_val),
        .match_count(match_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Search model: phase says which step of a search we are in; the run length and
    // pair count are plain integers, and the hit test is the run reaching the target.
    localparam int PH_IDLE = 0, PH_WAIT_PAIR = 1, PH_JUDGE = 2, PH_REPORT = 3;
    int m_phase;
    int m_run;
    int m_seen;
    int m_tgt;
    int m_y;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= PH_IDLE;
            m_run   <= 0;
            m_seen  <= 0;
            m_tgt   <= 0;
            m_y     <= 0;
        end else if (m_phase == PH_IDLE) begin
            if (start) begin
                m_tgt   <= int'(target);
                m_run   <= 0;
                m_seen  <= 0;
                m_y     <= (target == 0) ? 1 : 0;
                m_phase <= (target == 0) ? PH_REPORT : PH_WAIT_PAIR;
            end
        end else if (m_phase == PH_WAIT_PAIR) begin
            if (bit_valid) begin
                m_run   <= (a == b) ? ((m_run + 1 > 15) ? 15 : m_run + 1) : 0;
                m_seen  <= m_seen + 1;
                m_phase <= PH_JUDGE;
            end
        end else if (m_phase == PH_JUDGE) begin
            if (m_run == m_tgt || m_seen == MAXB) begin
                m_y     <= (m_run == m_tgt) ? 1 : 0;
                m_phase <= PH_REPORT;
            end else begin
                m_phase <= PH_WAIT_PAIR;
            end
        end else begin
            m_phase <= PH_IDLE;
        end
    end

    always @(negedge clk) begin
        check("m_bit_ready", bit_ready, (m_phase == PH_WAIT_PAIR));
        check("m_busy", busy, (m_phase == PH_WAIT_PAIR || m_phase == PH_JUDGE));
        check("m_done", done, (m_phase == PH_REPORT));
        check("m_y_val", y_val, m_y);
        check("m_match_count", match_count, m_run);
        check("m_in1", datapath_in1, m_run);
        check("m_in2", datapath_in2, m_tgt);
    end

    task automatic do_start(input logic [CW-1:0] tgt);
        start  = 1'b1;
        target = tgt;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic feed(input logic pa, input logic pb, input logic [CW-1:0] exp_cnt);
        int k = 0;
        while (!bit_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("ready_wait", bit_ready, 1);
        bit_valid = 1'b1;
        a         = pa;
        b         = pb;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        check("busy_in_check", busy, 1);
        check("run_cnt", match_count, exp_cnt);
    endtask

    // cnts holds the expected run count after each pair, 4 bits per pair, pair 0 lowest.
    task automatic search(input logic [CW-1:0] tgt, input int n, input logic [15:0] pa,
                          input logic [15:0] pb, input logic [63:0] cnts,
                          input logic exp_y, input logic [CW-1:0] exp_final);
        do_start(tgt);
        for (int i = 0; i < n; i++) begin
            feed(pa[i], pb[i], cnts[4*i +: 4]);
        end
        @(posedge clk); #1;
        check("done_pulse", done, 1);
        check("y_at_done", y_val, exp_y);
        check("cnt_at_done", match_count, exp_final);
        @(posedge clk); #1;
        check("done_cleared", done, 0);
        check("y_held", y_val, exp_y);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check("rst_bit_ready", bit_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_y", y_val, 0);
        check("rst_in1", datapath_in1, 0);
        check("rst_in2", datapath_in2, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // target 3, three equal pairs
        search(4'd3, 3, 16'b111, 16'b111, 64'h321, 1'b1, 4'd3);
        // target 2, eq,neq,eq,eq
        search(4'd2, 4, 16'b1111, 16'b1101, 64'h2101, 1'b1, 4'd2);
        // target 4, eq,eq,eq,neq,eq: runs out of pairs
        search(4'd4, 5, 16'b01000, 16'b00000, 64'h10321, 1'b0, 4'd1);
        // target 5, five equal pairs: hit on the last allowed pair wins
        search(4'd5, 5, 16'b10101, 16'b10101, 64'h54321, 1'b1, 4'd5);

        // target 0: immediate DONE, no pair ever requested
        do_start(4'd0);
        check("t0_done", done, 1);
        check("t0_y", y_val, 1);
        check("t0_ready", bit_ready, 0);
        @(posedge clk); #1;
        check("t0_done_clr", done, 0);
        check("t0_ready_idle", bit_ready, 0);
        check("t0_y_held", y_val, 1);

        // bit_valid held high: ready alternates, one pair consumed per two cycles
        bit_valid = 1'b1;
        a = 1'b1;
        b = 1'b1;
        do_start(4'd15);
        for (int c = 1; c <= 10; c++) begin
            check("alt_ready", bit_ready, c % 2);
            check("alt_cnt", match_count, c / 2);
            @(posedge clk); #1;
        end
        check("alt_done", done, 1);
        check("alt_y", y_val, 0);
        check("alt_cnt_final", match_count, 5);
        bit_valid = 1'b0;
        @(posedge clk); #1;

        // start and target disturbed during RUN: result follows the latched target 2
        do_start(4'd2);
        start  = 1'b1;
        target = 4'd1;
        feed(1'b1, 1'b1, 4'd1);
        start  = 1'b0;
        feed(1'b0, 1'b0, 4'd2);
        @(posedge clk); #1;
        check("dist_done", done, 1);
        check("dist_y", y_val, 1);
        check("dist_cnt", match_count, 2);
        @(posedge clk); #1;

        // reset while in CHECK aborts at once
        do_start(4'd3);
        feed(1'b1, 1'b1, 4'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_y", y_val, 0);
        check("abort_ready", bit_ready, 0);
        check("abort_cnt", match_count, 0);
        @(posedge clk); #1;
        check("abort_no_done", done, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        search(4'd3, 3, 16'b000, 16'b000, 64'h321, 1'b1, 4'd3);

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
